led_frame_sequencer: RTL

LED_FRAME_SEQUENCER -- requirements
Module: led_frame_sequencer

---
 rtl/led_pkg.sv | 26 ++
 rtl/color_wheel.sv | 39 +++
 rtl/led_frame_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// ============================================================================
//  Module      : led_pkg
//  Description : Shared state encoding and colour-mode codes for the LED
//                frame sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package led_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        START     = 3'd2,
        WAIT_DONE = 3'd3,
        LATCH     = 3'd4
    } state_t;

    localparam logic [1:0] MODE_SOLID    = 2'd0;
    localparam logic [1:0] MODE_GRADIENT = 2'd1;
    localparam logic [1:0] MODE_WHEEL    = 2'd2;
    localparam logic [1:0] MODE_OFF      = 2'd3;

endpackage

`default_nettype wire

// File: rtl/color_wheel.sv
// ============================================================================
//  Module      : color_wheel
//  Description : Combinational 8-bit hue to {R,G,B} colour-wheel mapping.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module color_wheel (
    input  logic [7:0]  hue,
    output logic [23:0] rgb
);

    logic [7:0] w_k;
    logic [7:0] w_up;
    logic [7:0] w_down;

    // Three 85-step segments; within each, one channel ramps up and one down.
    always_comb begin
        w_k = hue;
        if (hue >= 8'd170) begin
            w_k = hue - 8'd170;
        end else if (hue >= 8'd85) begin
            w_k = hue - 8'd85;
        end
        w_up   = w_k + w_k + w_k;
        w_down = 8'd255 - w_up;

        if (hue < 8'd85) begin
            rgb = {w_down, w_up, 8'h00};
        end else if (hue < 8'd170) begin
            rgb = {8'h00, w_down, w_up};
        end else begin
            rgb = {w_up, 8'h00, w_down};
        end
    end

endmodule

`default_nettype wire

// File: rtl/led_frame_sequencer.sv
// ============================================================================
//  Module      : led_frame_sequencer
//  Description : Turns audio level samples into LED strip frames: picks a
//                colour and lit-LED count, starts the driver, then latches.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module led_frame_sequencer
    import led_pkg::*;
#(
    parameter int NUM_LEDS       = 60,
    parameter int LATCH_CYCLES   = 2500,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        level_valid,
    input  logic [7:0]  level,
    output logic        level_ready,
    input  logic [1:0]  mode,
    input  logic        frame_done,
    output logic [23:0] color,
    output logic [6:0]  start_index,
    output logic        start,
    output logic        busy,
    output logic        timeout_err
);

    localparam int c_to_w  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int c_lat_w = (LATCH_CYCLES > 1)   ? $clog2(LATCH_CYCLES)   : 1;
    localparam logic [c_to_w-1:0]  c_to_last  = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_lat_w-1:0] c_lat_last = c_lat_w'(LATCH_CYCLES - 1);
    localparam logic [14:0]        c_num_leds = 15'(NUM_LEDS);

    state_t              r_state;
    logic [7:0]          r_level;
    logic [1:0]          r_mode;
    logic [7:0]          r_hue;
    logic [c_to_w-1:0]   r_to_cnt;
    logic [c_lat_w-1:0]  r_lat_cnt;
    logic [23:0]         r_color;
    logic [6:0]          r_start_index;
    logic                r_start;
    logic                r_timeout_err;

    logic [23:0]         w_wheel_rgb;
    logic [23:0]         w_color;
    logic [14:0]         w_product;

    color_wheel u_color_wheel (
        .hue (r_hue),
        .rgb (w_wheel_rgb)
    );

    assign w_product = {7'd0, r_level} * c_num_leds;

    always_comb begin
        w_color = 24'h000000;
        case (r_mode)
            MODE_SOLID:    w_color = 24'h00FF00;
            MODE_GRADIENT: w_color = {r_level, 8'd255 - r_level, 8'h00};
            MODE_WHEEL:    w_color = w_wheel_rgb;
            default:       w_color = 24'h000000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_level       <= 8'd0;
            r_mode        <= MODE_SOLID;
            r_hue         <= 8'd0;
            r_to_cnt      <= '0;
            r_lat_cnt     <= '0;
            r_color       <= 24'd0;
            r_start_index <= 7'd0;
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_start       <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (level_valid) begin
                        r_level <= level;
                        r_mode  <= mode;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_color       <= w_color;
                    r_start_index <= 7'(w_product >> 8);
                    r_state       <= START;
                end
                START: begin
                    r_start  <= 1'b1;
                    r_to_cnt <= '0;
                    r_state  <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    // A completed frame wins over a simultaneous timeout expiry.
                    if (frame_done) begin
                        r_hue     <= r_hue + 8'd1;
                        r_lat_cnt <= '0;
                        r_state   <= LATCH;
                    end else if (r_to_cnt == c_to_last) begin
                        r_timeout_err <= 1'b1;
                        r_lat_cnt     <= '0;
                        r_state       <= LATCH;
                    end else begin
                        r_to_cnt <= r_to_cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (r_lat_cnt == c_lat_last) begin
                        r_state <= IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign level_ready = (r_state == IDLE) && !reset;
    assign busy        = (r_state != IDLE);
    assign color       = r_color;
    assign start_index = r_start_index;
    assign start       = r_start;
    assign timeout_err = r_timeout_err;

endmodule

`default_nettype wire
